pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Generates hold and bubble-insert controls for the PC, IF/ID, ID/EX and EX/MEM registers. Resolves three hazard classes: load-use stall, taken-branch flush, and multi-cycle MDU (mult/div) occupancy of EX. Keeps saturating stall/flush performance counters and a sticky MDU timeout flag.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and sizing helpers for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int PERF_W_DEF      = 16;
    localparam int MDU_TIMEOUT_DEF = 64;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_e;

    // Busy counter must be able to hold every value up to the timeout.
    function automatic int busy_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: performance counter that sticks at all-ones instead of wrapping.
// Latency: increment visible one cycle after inc is sampled.
// Backpressure: none; inc is accepted every cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count up on inc unless already saturated.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: hazard sequencing (load-use stall, branch flush, MDU occupancy) for the 5-stage core.
// Latency: controls are combinational from state and inputs; counters/MDU_err lag one edge.
// Backpressure: Stall_* hold upstream registers; MDU occupancy bounded by MDU_TIMEOUT cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
    parameter int PERF_W      = PERF_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              EX_MemtoReg,
    input  logic [4:0]        EX_WriteReg,
    input  logic              EX_BranchTaken,
    input  logic              EX_MulDiv,
    input  logic              MDU_done,
    output logic              MDU_start,
    output logic              Stall_IF,
    output logic              Stall_ID,
    output logic              Stall_EX,
    output logic              Flush_ID,
    output logic              Flush_EX,
    output logic              Bubble_MEM,
    output logic              MDU_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int           BW        = busy_cnt_w(MDU_TIMEOUT);
    // busy_q counts completed busy cycles; the cycle seeing BUSY_LAST is the
    // MDU_TIMEOUT-th cycle of the sequence and must release.
    localparam logic [BW-1:0] BUSY_LAST = BW'(MDU_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] busy_q, busy_d;
    logic          err_q, err_set;
    logic          load_use;
    logic          start_c, hold_c, front_c, flush_id_c, flush_ex_c;

    assign load_use = EX_MemtoReg && (EX_WriteReg != 5'd0) &&
                      ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                       (ID_UsesRt && (ID_Rt == EX_WriteReg)));

    // State, busy counter and sticky timeout flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= RUN;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next state and raw controls; branch beats MDU entry beats load-use.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        err_set    = 1'b0;
        start_c    = 1'b0;
        hold_c     = 1'b0;
        front_c    = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        case (state_q)
            RUN: begin
                if (EX_BranchTaken) begin
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (EX_MulDiv) begin
                    start_c = 1'b1;
                    hold_c  = 1'b1;
                    busy_d  = '0;
                    state_d = MDU_BUSY;
                end else if (load_use) begin
                    front_c    = 1'b1;
                    flush_ex_c = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (MDU_done || (busy_q == BUSY_LAST)) begin
                    // Release: everything low so the result moves into EX/MEM.
                    err_set = !MDU_done;
                    state_d = RUN;
                end else begin
                    hold_c = 1'b1;
                    busy_d = busy_q + BW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Controls are forced low while reset is held.
    assign MDU_start  = RSTn & start_c;
    assign Stall_IF   = RSTn & (hold_c | front_c);
    assign Stall_ID   = RSTn & (hold_c | front_c);
    assign Stall_EX   = RSTn & hold_c;
    assign Bubble_MEM = RSTn & hold_c;
    assign Flush_ID   = RSTn & flush_id_c;
    assign Flush_EX   = RSTn & flush_ex_c;
    assign MDU_err    = err_q;

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .CLK  (CLK),
        .RSTn (RSTn),
        .inc  (Stall_IF),
        .cnt  (stall_cnt)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .CLK  (CLK),
        .RSTn (RSTn),
        .inc  (Flush_ID),
        .cnt  (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: self-checking bench for pipe_ctrl against a cycle-level behavioural model.
// Latency: model compares every cycle at the falling edge.
// Backpressure: n/a.
module tb_pipe_ctrl;

    localparam int TO   = 8;
    localparam int PW   = 8;
    localparam int CMAX = (1 << PW) - 1;

    logic          CLK, RSTn;
    logic [4:0]    ID_Rs, ID_Rt, EX_WriteReg;
    logic          ID_UsesRs, ID_UsesRt, EX_MemtoReg, EX_BranchTaken, EX_MulDiv, MDU_done;
    logic          MDU_start, Stall_IF, Stall_ID, Stall_EX, Flush_ID, Flush_EX, Bubble_MEM, MDU_err;
    logic [PW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: in an MDU sequence, m_n is cycles elapsed since MDU_start.
    bit m_busy;
    int m_n;
    int m_stall, m_flush;
    bit m_err;

    pipe_ctrl #(.MDU_TIMEOUT(TO), .PERF_W(PW)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRs      (ID_UsesRs),
        .ID_UsesRt      (ID_UsesRt),
        .EX_MemtoReg    (EX_MemtoReg),
        .EX_WriteReg    (EX_WriteReg),
        .EX_BranchTaken (EX_BranchTaken),
        .EX_MulDiv      (EX_MulDiv),
        .MDU_done       (MDU_done),
        .MDU_start      (MDU_start),
        .Stall_IF       (Stall_IF),
        .Stall_ID       (Stall_ID),
        .Stall_EX       (Stall_EX),
        .Flush_ID       (Flush_ID),
        .Flush_EX       (Flush_EX),
        .Bubble_MEM     (Bubble_MEM),
        .MDU_err        (MDU_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT against the model at the falling edge,
    // then advance the model across the rising edge.
    task automatic step();
        bit e_start, e_sif, e_sex, e_fid, e_fex;
        bit lu, nb, ne;
        int nn, ns, nf;
        @(negedge CLK);
        e_start = 0; e_sif = 0; e_sex = 0; e_fid = 0; e_fex = 0;
        nb = m_busy; nn = m_n; ne = m_err; ns = m_stall; nf = m_flush;
        lu = EX_MemtoReg && (EX_WriteReg != 0) &&
             ((ID_UsesRs && ID_Rs == EX_WriteReg) || (ID_UsesRt && ID_Rt == EX_WriteReg));
        if (RSTn) begin
            if (!m_busy) begin
                if (EX_BranchTaken) begin
                    e_fid = 1; e_fex = 1;
                end else if (EX_MulDiv) begin
                    e_start = 1; e_sif = 1; e_sex = 1;
                    nb = 1; nn = 1;
                end else if (lu) begin
                    e_sif = 1; e_fex = 1;
                end
            end else if (MDU_done || m_n == TO) begin
                nb = 0;
                if (!MDU_done) ne = 1;
            end else begin
                e_sif = 1; e_sex = 1;
                nn = m_n + 1;
            end
            if (e_sif) ns = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (e_fid) nf = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end
        chk("MDU_start",  32'(MDU_start),  int'(e_start));
        chk("Stall_IF",   32'(Stall_IF),   int'(e_sif));
        chk("Stall_ID",   32'(Stall_ID),   int'(e_sif));
        chk("Stall_EX",   32'(Stall_EX),   int'(e_sex));
        chk("Bubble_MEM", 32'(Bubble_MEM), int'(e_sex));
        chk("Flush_ID",   32'(Flush_ID),   int'(e_fid));
        chk("Flush_EX",   32'(Flush_EX),   int'(e_fex));
        chk("stall_cnt",  32'(stall_cnt),  RSTn ? m_stall : 0);
        chk("flush_cnt",  32'(flush_cnt),  RSTn ? m_flush : 0);
        chk("MDU_err",    32'(MDU_err),    RSTn ? int'(m_err) : 0);
        @(posedge CLK);
        if (!RSTn) begin
            m_busy = 0; m_n = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_busy = nb; m_n = nn; m_err = ne; m_stall = ns; m_flush = nf;
        end
        #1;
    endtask

    task automatic idle();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
        EX_MemtoReg = 0; EX_WriteReg = 0; EX_BranchTaken = 0;
        EX_MulDiv = 0; MDU_done = 0;
    endtask

    task automatic lu_ops();
        EX_MemtoReg = 1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1;
    endtask

    task automatic do_reset();
        idle();
        RSTn = 0;
        #1;
        chk("rst_Stall_IF",  32'(Stall_IF),  0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        step();
        step();
        RSTn = 1;
    endtask

    // MDU op with done asserted nd cycles after start (nd > TO: never).
    task automatic mdu_seq(input int nd);
        EX_MulDiv = 1;
        step();
        EX_MulDiv = 0;
        for (int k = 1; k <= TO; k++) begin
            MDU_done = (k == nd);
            step();
            if (k == nd) break;
        end
        MDU_done = 0;
    endtask

    initial begin
        RSTn = 0;
        idle();
        m_busy = 0; m_n = 0; m_err = 0; m_stall = 0; m_flush = 0;
        do_reset();

        // Load-use on Rs: one stall cycle, then the bubble clears it.
        lu_ops();
        #1;
        chk("lu_Stall_IF", 32'(Stall_IF), 1);
        chk("lu_Stall_ID", 32'(Stall_ID), 1);
        chk("lu_Flush_EX", 32'(Flush_EX), 1);
        step();
        idle();
        #1;
        chk("lu_after_Stall_IF", 32'(Stall_IF), 0);
        chk("lu_after_Flush_EX", 32'(Flush_EX), 0);
        step();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);

        // $zero destination and unused Rt never stall.
        do_reset();
        EX_MemtoReg = 1; EX_WriteReg = 0; ID_Rs = 0; ID_UsesRs = 1;
        #1;
        chk("zero_Stall_IF", 32'(Stall_IF), 0);
        step();
        EX_WriteReg = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 0; ID_UsesRs = 0;
        #1;
        chk("rt_unused_Stall_IF", 32'(Stall_IF), 0);
        step();
        idle();
        chk("zero_stall_cnt", 32'(stall_cnt), 0);

        // Branch masks a coincident load-use.
        do_reset();
        lu_ops();
        EX_BranchTaken = 1;
        #1;
        chk("br_Flush_ID", 32'(Flush_ID), 1);
        chk("br_Flush_EX", 32'(Flush_EX), 1);
        chk("br_Stall_IF", 32'(Stall_IF), 0);
        step();
        idle();
        step();
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 0);

        // MDU with done four cycles after start.
        do_reset();
        EX_MulDiv = 1;
        #1;
        chk("mdu_start_t0", 32'(MDU_start), 1);
        chk("mdu_Stall_EX_t0", 32'(Stall_EX), 1);
        step();
        EX_MulDiv = 0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("mdu_start_busy", 32'(MDU_start), 0);
            chk("mdu_Bubble_busy", 32'(Bubble_MEM), 1);
            step();
        end
        MDU_done = 1;
        #1;
        chk("mdu_rel_Stall_IF", 32'(Stall_IF), 0);
        chk("mdu_rel_Bubble", 32'(Bubble_MEM), 0);
        step();
        MDU_done = 0;
        chk("mdu_stall_cnt", 32'(stall_cnt), 4);
        chk("mdu_err_clean", 32'(MDU_err), 0);

        // Timeout without done: TO stall cycles, sticky error, back in RUN.
        do_reset();
        mdu_seq(TO + 1);
        chk("to_MDU_err", 32'(MDU_err), 1);
        chk("to_stall_cnt", 32'(stall_cnt), TO);
        lu_ops();
        #1;
        chk("to_run_Stall_IF", 32'(Stall_IF), 1);
        chk("to_run_Bubble", 32'(Bubble_MEM), 0);
        step();
        idle();
        step();
        chk("to_err_sticky", 32'(MDU_err), 1);

        // Done on the timeout cycle counts as done.
        do_reset();
        mdu_seq(TO);
        chk("to_done_err", 32'(MDU_err), 0);
        chk("to_done_stall_cnt", 32'(stall_cnt), TO);

        // Reset in the middle of a busy period.
        do_reset();
        EX_MulDiv = 1;
        step();
        EX_MulDiv = 0;
        step();
        step();
        RSTn = 0;
        #1;
        chk("midrst_Stall_IF", 32'(Stall_IF), 0);
        chk("midrst_Bubble", 32'(Bubble_MEM), 0);
        step();
        RSTn = 1;
        chk("midrst_stall_cnt", 32'(stall_cnt), 0);
        chk("midrst_err", 32'(MDU_err), 0);
        lu_ops();
        #1;
        chk("midrst_run_Bubble", 32'(Bubble_MEM), 0);
        chk("midrst_run_Stall_IF", 32'(Stall_IF), 1);
        step();
        idle();

        // Saturation: drive well past all-ones, then one more stall.
        do_reset();
        for (int s = 0; s < (CMAX / TO) + 2; s++) mdu_seq(TO + 1);
        chk("sat_stall_cnt", 32'(stall_cnt), CMAX);
        lu_ops();
        step();
        idle();
        chk("sat_hold", 32'(stall_cnt), CMAX);

        // Randomised traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            RSTn           = ($urandom_range(0, 399) != 0);
            ID_Rs          = 5'($urandom_range(0, 3));
            ID_Rt          = 5'($urandom_range(0, 3));
            ID_UsesRs      = 1'($urandom_range(0, 1));
            ID_UsesRt      = 1'($urandom_range(0, 1));
            EX_MemtoReg    = 1'($urandom_range(0, 1));
            EX_WriteReg    = 5'($urandom_range(0, 3));
            EX_BranchTaken = ($urandom_range(0, 9) == 0);
            EX_MulDiv      = ($urandom_range(0, 7) == 0);
            MDU_done       = ($urandom_range(0, 5) == 0);
            step();
        end
        RSTn = 1;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
